// File: rtl/timer_pkg.sv
// Register map, bit positions and bus constants shared by the timer and its users.
package timer_pkg;

  localparam int WORD_DATA_W = 32;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [1:0] TIMER_ADDR_CTRL    = 2'd0;
  localparam logic [1:0] TIMER_ADDR_INTR    = 2'd1;
  localparam logic [1:0] TIMER_ADDR_EXPR    = 2'd2;
  localparam logic [1:0] TIMER_ADDR_COUNTER = 2'd3;

  localparam int TIMER_START_LOC = 0;
  localparam int TIMER_MODE_LOC  = 1;
  localparam int TIMER_IRQ_LOC   = 0;
  localparam int TIMER_PRESC_LOC = 8;

  typedef enum logic {
    TIMER_MODE_ONE_SHOT = 1'b0,
    TIMER_MODE_PERIODIC = 1'b1
  } timer_mode_e;

endpackage

// File: rtl/timer.sv
// Memory-mapped interval timer with a sticky level IRQ; one-shot and periodic modes.
// Optional prescaler on CTRL[15:8] is enabled by defining TIMER_PRESCALER_EN.
module timer
  import timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [1:0]             addr,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic [WORD_DATA_W-1:0] rd_data,
  output logic                   rdy_,
  output logic                   irq
);

  if (CNT_W > WORD_DATA_W) begin : gCntWidthCheck
    $error("timer: CNT_W must not exceed WORD_DATA_W");
  end
  if (PRESC_W > 8) begin : gPrescWidthCheck
    $error("timer: PRESC_W must fit in CTRL[15:8]");
  end

  logic                   access, wrEn, rdEn, ctrlWrite, tick, expiry;
  logic                   start_q, start_d;
  timer_mode_e            mode_q, mode_d;
  logic [CNT_W-1:0]       expr_q, expr_d;
  logic [CNT_W-1:0]       counter_q, counter_d;
  logic                   irq_q, irq_d;
  logic                   rdy_q, rdy_d;
  logic [WORD_DATA_W-1:0] rdData_q, rdData_d;
  logic [WORD_DATA_W-1:0] ctrlWord, regVal;

  assign access    = (cs_ == ENABLE_) && (as_ == ENABLE_);
  assign wrEn      = access && (rw == WRITE);
  assign rdEn      = access && (rw == READ);
  assign ctrlWrite = wrEn && (addr == TIMER_ADDR_CTRL);

`ifdef TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] tick_q, tick_d;

  // Tick counter restarts whenever the timer is idle or CTRL is rewritten.
  assign tick = (tick_q == presc_q);

  always_comb begin
    presc_d = presc_q;
    tick_d  = tick_q;
    if (ctrlWrite) begin
      presc_d = wr_data[TIMER_PRESC_LOC +: PRESC_W];
      tick_d  = '0;
    end else if (!start_q || tick) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign expiry = start_q && tick && (counter_q == expr_q);

  always_comb begin
    ctrlWord                  = '0;
    ctrlWord[TIMER_START_LOC] = start_q;
    ctrlWord[TIMER_MODE_LOC]  = mode_q;
`ifdef TIMER_PRESCALER_EN
    ctrlWord[TIMER_PRESC_LOC +: PRESC_W] = presc_q;
`endif
    regVal = '0;
    case (addr)
      TIMER_ADDR_CTRL:    regVal = ctrlWord;
      TIMER_ADDR_INTR:    regVal[TIMER_IRQ_LOC] = irq_q;
      TIMER_ADDR_EXPR:    regVal[CNT_W-1:0] = expr_q;
      TIMER_ADDR_COUNTER: regVal[CNT_W-1:0] = counter_q;
      default:            regVal = '0;
    endcase
  end

  // Counting first, then bus writes override; an expiry always leaves irq set.
  always_comb begin
    start_d   = start_q;
    mode_d    = mode_q;
    expr_d    = expr_q;
    counter_d = counter_q;
    irq_d     = irq_q;
    if (start_q && tick) begin
      if (expiry) begin
        counter_d = '0;
        irq_d     = ENABLE;
        if (mode_q == TIMER_MODE_ONE_SHOT) start_d = 1'b0;
      end else begin
        counter_d = counter_q + CNT_W'(1);
      end
    end
    if (wrEn) begin
      case (addr)
        TIMER_ADDR_CTRL: begin
          start_d = wr_data[TIMER_START_LOC];
          mode_d  = timer_mode_e'(wr_data[TIMER_MODE_LOC]);
        end
        TIMER_ADDR_INTR:    irq_d     = wr_data[TIMER_IRQ_LOC];
        TIMER_ADDR_EXPR:    expr_d    = wr_data[CNT_W-1:0];
        TIMER_ADDR_COUNTER: counter_d = wr_data[CNT_W-1:0];
        default:            ;
      endcase
    end
    if (expiry) irq_d = ENABLE;
    rdData_d = rdEn ? regVal : '0;
    rdy_d    = access ? ENABLE_ : DISABLE_;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q   <= 1'b0;
      mode_q    <= TIMER_MODE_ONE_SHOT;
      expr_q    <= '0;
      counter_q <= '0;
      irq_q     <= DISABLE;
      rdy_q     <= DISABLE_;
      rdData_q  <= '0;
    end else begin
      start_q   <= start_d;
      mode_q    <= mode_d;
      expr_q    <= expr_d;
      counter_q <= counter_d;
      irq_q     <= irq_d;
      rdy_q     <= rdy_d;
      rdData_q  <= rdData_d;
    end
  end

  assign rd_data = rdData_q;
  assign rdy_    = rdy_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for the interval timer: bus reads are scoreboarded,
// irq timing is checked inline by each scenario.
module tb_timer;
  import timer_pkg::*;

  logic        clk;
  logic        reset;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        irq;

  int checkCount = 0;
  int passCount  = 0;
  logic [31:0] expQ[$];
  logic accPrev;
  logic rdPrev;

`ifdef TIMER_PRESCALER_EN
  localparam int          PRESC_EXPIRY = 8;
  localparam logic [31:0] PRESC_CTRL_RB = 32'h0000_0301;
  localparam logic [31:0] PRESC_CTRL_DONE = 32'h0000_0300;
  localparam logic [31:0] MASK_CTRL_RB = 32'h0000_FF00;
`else
  localparam int          PRESC_EXPIRY = 2;
  localparam logic [31:0] PRESC_CTRL_RB = 32'h0000_0001;
  localparam logic [31:0] PRESC_CTRL_DONE = 32'h0000_0000;
  localparam logic [31:0] MASK_CTRL_RB = 32'h0000_0000;
`endif

  timer dut (
    .clk     (clk),
    .reset   (reset),
    .cs_     (cs_),
    .as_     (as_),
    .rw      (rw),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rdy_    (rdy_),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remember which edges saw an access so the following half-cycle can be judged.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      accPrev = 1'b0;
      rdPrev  = 1'b0;
      expQ.delete();
    end else begin
      accPrev = (cs_ === 1'b0) && (as_ === 1'b0);
      rdPrev  = accPrev && (rw === READ);
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (accPrev || rdy_ !== 1'b1) begin
        checkCount++;
        if (rdy_ !== (accPrev ? 1'b0 : 1'b1))
          $display("[TB] FAIL rdy_ got=%b required=%b at %0t", rdy_, accPrev ? 1'b0 : 1'b1, $time);
        else passCount++;
      end
      if (rdPrev) begin
        checkCount++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL read_data no expected entry, got=%h at %0t", rd_data, $time);
        end else begin
          logic [31:0] e;
          e = expQ.pop_front();
          if (rd_data !== e)
            $display("[TB] FAIL read_data got=%h required=%h at %0t", rd_data, e, $time);
          else passCount++;
        end
      end else if (rd_data !== 32'h0) begin
        checkCount++;
        $display("[TB] FAIL idle_rd_data got=%h required=0 at %0t", rd_data, $time);
      end
    end
  end

  task automatic applyStimulus(input logic acc, input logic rwv, input logic [1:0] a,
                               input logic [31:0] d, input logic [31:0] expRd);
    @(negedge clk);
    cs_     = ~acc;
    as_     = ~acc;
    rw      = rwv;
    addr    = a;
    wr_data = d;
    if (acc && rwv == READ) expQ.push_back(expRd);
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(1'b1, WRITE, a, d, 32'h0);
  endtask

  task automatic busRead(input logic [1:0] a, input logic [31:0] e);
    applyStimulus(1'b1, READ, a, 32'h0, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, READ, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cs_ = 1'b1; as_ = 1'b1; rw = READ; addr = 2'd0; wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkCount++;
    if (rd_data !== 32'h0 || rdy_ !== 1'b1 || irq !== 1'b0)
      $display("[TB] FAIL reset_outputs got rd=%h rdy_=%b irq=%b required 0/1/0", rd_data, rdy_, irq);
    else passCount++;
    for (int r = 0; r < 4; r++) busRead(r[1:0], 32'h0);
    idle(2);
  endtask

  task automatic test_back_to_back;
    busWrite(TIMER_ADDR_EXPR, 32'hA5A5_F00F);
    busWrite(TIMER_ADDR_COUNTER, 32'h1234_5678);
    busWrite(TIMER_ADDR_INTR, 32'h1);
    busRead(TIMER_ADDR_EXPR, 32'hA5A5_F00F);
    busRead(TIMER_ADDR_COUNTER, 32'h1234_5678);
    busRead(TIMER_ADDR_INTR, 32'h1);
    busWrite(TIMER_ADDR_CTRL, 32'hFFFF_FF00);
    busRead(TIMER_ADDR_CTRL, MASK_CTRL_RB);
    busWrite(TIMER_ADDR_CTRL, 32'h0);
    busWrite(TIMER_ADDR_INTR, 32'h0);
    busRead(TIMER_ADDR_INTR, 32'h0);
    idle(2);
  endtask

  task automatic test_one_shot;
    busWrite(TIMER_ADDR_COUNTER, 32'h0);
    busWrite(TIMER_ADDR_EXPR, 32'd5);
    busWrite(TIMER_ADDR_CTRL, 32'h1);
    for (int k = 0; k <= 6; k++) begin
      idle(1);
      checkCount++;
      if (irq !== (k >= 6))
        $display("[TB] FAIL one_shot_irq k=%0d got=%b required=%b", k, irq, k >= 6);
      else passCount++;
    end
    busRead(TIMER_ADDR_CTRL, 32'h0);
    busRead(TIMER_ADDR_COUNTER, 32'h0);
    idle(1);
    checkCount++;
    if (irq !== 1'b1) $display("[TB] FAIL one_shot_sticky got=%b required=1", irq);
    else passCount++;
    busWrite(TIMER_ADDR_INTR, 32'h0);
    idle(1);
    checkCount++;
    if (irq !== 1'b0) $display("[TB] FAIL intr_clear got=%b required=0", irq);
    else passCount++;
  endtask

  task automatic test_expr_zero;
    busWrite(TIMER_ADDR_COUNTER, 32'h0);
    busWrite(TIMER_ADDR_EXPR, 32'h0);
    busWrite(TIMER_ADDR_CTRL, 32'h1);
    for (int k = 0; k <= 3; k++) begin
      if (k == 1) busRead(TIMER_ADDR_CTRL, 32'h0);
      else idle(1);
      checkCount++;
      if (irq !== (k >= 1))
        $display("[TB] FAIL expr_zero_irq k=%0d got=%b required=%b", k, irq, k >= 1);
      else passCount++;
    end
    busWrite(TIMER_ADDR_INTR, 32'h0);
    idle(1);
  endtask

  task automatic test_periodic;
    busWrite(TIMER_ADDR_COUNTER, 32'h0);
    busWrite(TIMER_ADDR_EXPR, 32'd3);
    busWrite(TIMER_ADDR_CTRL, 32'h3);
    for (int k = 0; k <= 8; k++) begin
      logic e;
      if (k == 4) busWrite(TIMER_ADDR_INTR, 32'h0);
      else if (k == 6) busRead(TIMER_ADDR_COUNTER, 32'd2);
      else idle(1);
      e = (k == 4) || (k == 8);
      checkCount++;
      if (irq !== e) $display("[TB] FAIL periodic_irq k=%0d got=%b required=%b", k, irq, e);
      else passCount++;
    end
    busWrite(TIMER_ADDR_CTRL, 32'h0);
    busWrite(TIMER_ADDR_INTR, 32'h0);
    idle(1);
  endtask

  task automatic test_set_vs_clear;
    busWrite(TIMER_ADDR_COUNTER, 32'h0);
    busWrite(TIMER_ADDR_EXPR, 32'd2);
    busWrite(TIMER_ADDR_INTR, 32'h0);
    busWrite(TIMER_ADDR_CTRL, 32'h3);
    for (int k = 0; k <= 8; k++) begin
      if (k == 2 || k == 3) busWrite(TIMER_ADDR_INTR, 32'h0);
      else if (k == 5) busWrite(TIMER_ADDR_COUNTER, 32'd1);
      else if (k == 7) busRead(TIMER_ADDR_COUNTER, 32'd2);
      else idle(1);
      if (k >= 3 && k <= 6) begin
        checkCount++;
        if (irq !== (k == 3 || k == 6))
          $display("[TB] FAIL set_wins_irq k=%0d got=%b required=%b", k, irq, (k == 3 || k == 6));
        else passCount++;
      end
    end
    busWrite(TIMER_ADDR_CTRL, 32'h0);
    busWrite(TIMER_ADDR_INTR, 32'h0);
    idle(1);
  endtask

  task automatic test_wrap;
    busWrite(TIMER_ADDR_COUNTER, 32'hFFFF_FFFE);
    busWrite(TIMER_ADDR_EXPR, 32'd5);
    busWrite(TIMER_ADDR_CTRL, 32'h3);
    for (int k = 0; k <= 3; k++) begin
      if (k == 2) busRead(TIMER_ADDR_COUNTER, 32'h0);
      else idle(1);
      checkCount++;
      if (irq !== 1'b0) $display("[TB] FAIL wrap_irq k=%0d got=%b required=0", k, irq);
      else passCount++;
    end
    busWrite(TIMER_ADDR_CTRL, 32'h0);
    idle(1);
  endtask

  task automatic test_prescaler;
    busWrite(TIMER_ADDR_COUNTER, 32'h0);
    busWrite(TIMER_ADDR_EXPR, 32'd1);
    busWrite(TIMER_ADDR_INTR, 32'h0);
    busWrite(TIMER_ADDR_CTRL, 32'h0000_0301);
    for (int k = 0; k <= 8; k++) begin
      if (k == 0) busRead(TIMER_ADDR_CTRL, PRESC_CTRL_RB);
      else idle(1);
      checkCount++;
      if (irq !== (k >= PRESC_EXPIRY))
        $display("[TB] FAIL prescaler_irq k=%0d got=%b required=%b", k, irq, k >= PRESC_EXPIRY);
      else passCount++;
    end
    busRead(TIMER_ADDR_CTRL, PRESC_CTRL_DONE);
    busWrite(TIMER_ADDR_CTRL, 32'h0);
    busWrite(TIMER_ADDR_INTR, 32'h0);
    idle(1);
  endtask

  task automatic test_reset_mid_count;
    busWrite(TIMER_ADDR_INTR, 32'h1);
    busWrite(TIMER_ADDR_COUNTER, 32'h0);
    busWrite(TIMER_ADDR_EXPR, 32'd100);
    busWrite(TIMER_ADDR_CTRL, 32'h3);
    idle(7);
    busRead(TIMER_ADDR_COUNTER, 32'd7);
    @(posedge clk);
    #2;
    reset = 1'b1;
    cs_ = 1'b1; as_ = 1'b1;
    #1;
    checkCount++;
    if (rdy_ !== 1'b1 || rd_data !== 32'h0 || irq !== 1'b0)
      $display("[TB] FAIL reset_mid got rdy_=%b rd=%h irq=%b required 1/0/0", rdy_, rd_data, irq);
    else passCount++;
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    for (int r = 0; r < 4; r++) busRead(r[1:0], 32'h0);
    idle(3);
    checkCount++;
    if (irq !== 1'b0) $display("[TB] FAIL reset_mid_irq got=%b required=0", irq);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_one_shot();
    test_expr_zero();
    test_periodic();
    test_set_vs_clear();
    test_wrap();
    test_prescaler();
    test_reset_mid_count();
    idle(2);
    checkCount++;
    if (expQ.size() != 0) $display("[TB] FAIL pending_reads left=%0d required=0", expQ.size());
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
